apb_spi_regs: RTL

- APB3 slave register front end for the SPI master; sits directly upstream of the SPI `control` sequencer.
- Buffers CPU write data in a small TX FIFO and issues one-cycle `send` requests to `control` together with the byte to shift.
- Captures the received byte when `control` pulses `done`, and exposes status and interrupt to the CPU.

---
 rtl/apb_spi_regs_if.sv | 24 ++
 rtl/apb_spi_regs.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_regs_if.sv
// APB3 bus bundle between the CPU-side master and the SPI register block.
// The master modport drives the request; the slave modport drives the response.
interface apb_spi_regs_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_spi_regs.sv
// APB3 register front end for the SPI master: TX FIFO, send sequencer towards
// the SPI control block, RX capture, status and a registered interrupt.
module apb_spi_regs #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    apb_spi_regs_if.slave     apb,
    output logic              send_o,
    output logic [DATA_W-1:0] tx_data_o,
    input  logic              done_i,
    input  logic [DATA_W-1:0] rx_data_i,
    output logic              irq_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [ADDR_W-3:0] IdxTx   = (ADDR_W-2)'(0);
    localparam logic [ADDR_W-3:0] IdxRx   = (ADDR_W-2)'(1);
    localparam logic [ADDR_W-3:0] IdxSt   = (ADDR_W-2)'(2);
    localparam logic [ADDR_W-3:0] IdxCtrl = (ADDR_W-2)'(3);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              send_q, send_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              enable_q, enable_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;

    logic              access, wr, rd;
    logic [ADDR_W-3:0] word_idx;
    logic              fifo_full, fifo_empty, busy;
    logic              push, pop, rx_rd, ovr_clr, ctrl_wr, done_evt;
    logic [31:0]       status_word;
    logic [31:0]       rdata;
    logic              err;

    assign access   = apb.psel & apb.penable;
    assign wr       = access & apb.pwrite;
    assign rd       = access & ~apb.pwrite;
    assign word_idx = apb.paddr[ADDR_W-1:2];

    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q == StBusy);
    assign done_evt   = busy & done_i;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push    = wr & (word_idx == IdxTx) & (~fifo_full | pop);
    assign rx_rd   = rd & (word_idx == IdxRx);
    assign ovr_clr = wr & (word_idx == IdxSt) & apb.pwdata[4];
    assign ctrl_wr = wr & (word_idx == IdxCtrl);

    always_comb begin
        status_word      = '0;
        status_word[0]   = busy;
        status_word[1]   = fifo_full;
        status_word[2]   = fifo_empty;
        status_word[3]   = rx_valid_q;
        status_word[4]   = overrun_q;
        status_word[7:5] = 3'(count_q);
    end

    always_comb begin
        rdata = '0;
        err   = 1'b0;
        if (access) begin
            case (word_idx)
                IdxTx: begin
                    if (apb.pwrite) err = fifo_full & ~pop;
                    else            err = 1'b1;
                end
                IdxRx: begin
                    if (apb.pwrite) err = 1'b1;
                    else            rdata = 32'(rx_q);
                end
                IdxSt: begin
                    if (!apb.pwrite) rdata = status_word;
                end
                IdxCtrl: begin
                    if (!apb.pwrite) rdata = {30'b0, irq_en_q, enable_q};
                end
                default: err = 1'b1;
            endcase
        end
    end

    assign apb.prdata  = rdata;
    assign apb.pslverr = err;
    assign apb.pready  = 1'b1;

    // Send sequencer: a frame is launched only from idle, so the next send
    // cannot appear before the cycle following done.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_q && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (done_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (!push && pop) count_d = count_q - CntW'(1);
        send_d    = pop;
        tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
        rx_d      = done_evt ? rx_data_i : rx_q;
    end

    // A read racing with done returns the old byte and leaves rx_valid set
    // without flagging overrun; a new overrun beats a concurrent clear.
    always_comb begin
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (done_evt)   rx_valid_d = 1'b1;
        else if (rx_rd) rx_valid_d = 1'b0;
        if (done_evt && rx_valid_q && !rx_rd) overrun_d = 1'b1;
        else if (ovr_clr)                     overrun_d = 1'b0;
        enable_d = ctrl_wr ? apb.pwdata[0] : enable_q;
        irq_en_d = ctrl_wr ? apb.pwdata[1] : irq_en_q;
        irq_d    = irq_en_q & (rx_valid_q | overrun_q);
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            send_q     <= 1'b0;
            tx_data_q  <= '0;
            rx_q       <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            send_q     <= send_d;
            tx_data_q  <= tx_data_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= apb.pwdata[DATA_W-1:0];
    end

    assign send_o    = send_q;
    assign tx_data_o = tx_data_q;
    assign irq_o     = irq_q;

endmodule
